shared_mem_arbiter: RTL and testbench
=====================================

# shared_mem_arbiter

Sequential arbiter for the single data port of the shared instruction/data memory. It shares that port among three requesters: the CPU load/store path, the RAS spill/fill engine and the UART/SPI DMA engine. The CPU has priority. The two secondary requesters are served round-robin in CPU-idle cycles. A starvation guard can stall the CPU so that a secondary requester is served. The block sits between the memory-region decoder and the memory interface, and returns read data to the owner of each access one cycle later.

## Interface
- AW, 32, address width of all requester and memory address buses
- DW, 32, data width
- BASE_OFFSET, 32'h2000, subtracted from every granted address before it reaches the memory
- STARVE_LIMIT, 8, number of consecutive ungranted cycles of a pending secondary request before a forced grant; legal range 1–255
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_rd, cpu_wr  in  1 each  CPU access strobes, already qualified as non-MMIO
- cpu_addr  in  AW  CPU byte address
- cpu_din  in  DW  CPU write data
- cpu_wen  in  4  CPU byte enables
- cpu_strctrl  in  3  CPU store control
- cpu_dout  out  DW  CPU read data
- cpu_hold  out  1  stall request to the CPU pipeline
- ras_req_rd, ras_req_wr  in  1 each  RAS access request
- ras_addr  in  AW  RAS address
- ras_din  in  DW  RAS write data
- ras_gnt  out  1  RAS grant pulse
- ras_rvalid  out  1  RAS read data valid
- ras_dout  out  DW  RAS read data
- dma_req_rd, dma_req_wr, dma_addr, dma_din, dma_gnt, dma_rvalid, dma_dout  same as the RAS group, for the DMA engine
- mem_en  out  1  memory port enable
- mem_wen  out  4  memory byte write enables
- mem_strctrl  out  3  memory store control
- mem_addr  out  AW  memory address, equal to the granted address − BASE_OFFSET
- mem_din  out  DW  memory write data
- mem_dout  in  DW  memory read data; synchronous, 1-cycle latency

## Operation
- Per-cycle arbitration. The grant is combinational from the current requests and registered state.
- When cpu_rd|cpu_wr is asserted and no forced grant is active, the CPU owns the port. The CPU has no grant signal: it is served whenever cpu_hold=0.
- When the CPU is idle, one secondary requester is granted. If both request, the round-robin pointer picks; after each secondary grant the pointer moves to the other requester.
- Secondary writes always drive mem_wen=4'b1111 and mem_strctrl=3'b100 (word store). Secondary reads drive mem_wen=0 and mem_strctrl=3'b000.
- A secondary request (rd or wr, never both) must stay stable until its gnt pulse. The requester may drop it, or present a new request, in the cycle after gnt.
- Owner register:
  - Records the owner of each read: NONE, CPU, RAS or DMA.
  - In the next cycle, mem_dout is routed to that owner's dout and the matching rvalid pulses.
  - cpu_dout is always driven with mem_dout.
  - ras_dout and dma_dout hold their last value when not valid.
- Starvation counter:
  - Increments every cycle in which a secondary request is pending and ungranted.
  - Clears on any secondary grant, or when no secondary request is pending.
  - Saturates at STARVE_LIMIT.
- No access is ever dropped. Simultaneous requests from all three requesters resolve to exactly one owner per cycle.

## Timing
- Reset values:
  - All outputs 0, except cpu_dout, ras_dout and dma_dout, which are 0 but follow their routing rules after reset.
  - Round-robin pointer = RAS; owner = NONE; counter = 0.
- Reset asserted mid-access: the pending rvalid is suppressed and no gnt is issued in the reset cycle.
- Grant latency:
  - Secondary requester with the CPU idle: 0 cycles (gnt in the same cycle as req).
  - Read data: rvalid exactly 1 cycle after gnt.
- Forced grant:
  - Issued in the cycle the counter equals STARVE_LIMIT while the CPU is requesting.
  - In that cycle cpu_hold=1 and the secondary requester gets the port.
  - The CPU must hold its request stable; it is served in the following cycle.
  - cpu_hold is never asserted for two consecutive cycles.
- Counter wrap: the counter never wraps. At saturation it waits for a grant.
- The address subtraction wraps modulo 2^AW.

## Configuration
- SHARED_MEM_STARVE_GUARD_EN defined: the starvation counter, forced grant and cpu_hold logic are present.
- Not defined: cpu_hold is tied to 0, the counter is removed, and secondary requesters are served only in CPU-idle cycles. Unbounded waiting is permitted.

## Structure
- Package shared_mem_arb_pkg holds:
  - owner_e enum: OWN_NONE, OWN_CPU, OWN_RAS, OWN_DMA.
  - STORE_WORD = 3'b100 and STORE_NONE = 3'b000.
  - DEFAULT_BASE_OFFSET.
- Sub-module arb_rr2: 2-way round-robin picker. It holds the pointer register and takes req[1:0] and an advance strobe, and outputs a one-hot grant.

## Test plan
- CPU read at 0x2010 with RAS idle → mem_addr=0x10, mem_en=1, cpu_hold=0; next cycle cpu_dout=mem_dout and ras_rvalid=0.
- RAS write to 0x2040 (data 0xDEADBEEF) and DMA read at 0x2080 in the same cycle, CPU idle → cycle 0: ras_gnt with mem_wen=4'hF, mem_strctrl=3'b100; cycle 1: dma_gnt; cycle 2: dma_rvalid=1.
- CPU requesting continuously while RAS requests, STARVE_LIMIT=8, guard enabled → ras_gnt and cpu_hold=1 in cycle 8 only, then the CPU resumes; with the guard disabled, no ras_gnt until the CPU goes idle.
- Alternating RAS and DMA reads, both held for 6 CPU-idle cycles → grants alternate R,D,R,D,R,D; every rvalid arrives 1 cycle after its gnt.
- rst asserted the cycle after a RAS read grant → ras_rvalid=0 and all outputs 0; the pointer returns to RAS.
- DMA read at 0x0000 → mem_addr=0xFFFFE000; dma_rvalid follows next cycle.

Source files
------------

// File: rtl/shared_mem_arbiter_pkg.sv
// Shared types and constants for the shared memory data-port arbiter.
//   owner_e             : owner of the read that is in flight in the memory
//   STORE_WORD/NONE     : store-control codes driven for secondary accesses
//   WEN_WORD/NONE       : byte-enable patterns driven for secondary accesses
//   DEFAULT_BASE_OFFSET : default offset removed from every granted address
package shared_mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_RAS,
    OWN_DMA
  } owner_e;

  localparam logic [2:0] STORE_WORD = 3'b100;
  localparam logic [2:0] STORE_NONE = 3'b000;

  localparam logic [3:0] WEN_WORD = 4'b1111;
  localparam logic [3:0] WEN_NONE = 4'b0000;

  localparam logic [31:0] DEFAULT_BASE_OFFSET = 32'h0000_2000;

endpackage

// File: rtl/shared_mem_arbiter_rr2.sv
// arb_rr2: two-way round-robin picker.
//   clk, rst : clock, synchronous active-high reset
//   req      : request vector, bit 0 = first requester, bit 1 = second
//   advance  : a grant from this picker was consumed this cycle
//   gnt      : one-hot pick (zero when nobody requests)
// The pointer names the requester that wins a tie. After a consumed grant
// it moves to the requester that was not granted. Reset points at bit 0.
module arb_rr2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && (gnt != 2'b00)) begin
      // Bit 0 granted -> bit 1 wins the next tie, and vice versa.
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: arbitrates the single data port of the shared
// instruction/data memory between the CPU load/store path (priority), the
// RAS spill/fill engine and the UART/SPI DMA engine (round-robin between
// the two secondaries in CPU-idle cycles).
//   cpu_*  : CPU strobes, address, write data/enables/store control; read
//            data; cpu_hold stalls the CPU for one forced secondary grant
//   ras_*  : RAS request (rd/wr), address, write data; gnt pulse, rvalid,
//            read data (held between valid pulses)
//   dma_*  : same as RAS, for the DMA engine
//   mem_*  : memory port; mem_addr = granted address - BASE_OFFSET
//            (mod 2^AW); mem_dout arrives one cycle after the access
// Build option: define SHARED_MEM_STARVE_GUARD_EN to include the starvation
// counter and the forced grant that stalls the CPU via cpu_hold. Without it
// cpu_hold is tied low and secondaries wait for CPU-idle cycles.
module shared_mem_arbiter
  import shared_mem_arb_pkg::*;
#(
  parameter int unsigned     AW           = 32,
  parameter int unsigned     DW           = 32,
  parameter logic [AW-1:0]   BASE_OFFSET  = AW'(DEFAULT_BASE_OFFSET),
  parameter int unsigned     STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  // CPU
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic [3:0]    cpu_wen,
  input  logic [2:0]    cpu_strctrl,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_hold,
  // RAS spill/fill engine
  input  logic          ras_req_rd,
  input  logic          ras_req_wr,
  input  logic [AW-1:0] ras_addr,
  input  logic [DW-1:0] ras_din,
  output logic          ras_gnt,
  output logic          ras_rvalid,
  output logic [DW-1:0] ras_dout,
  // DMA engine
  input  logic          dma_req_rd,
  input  logic          dma_req_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_din,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_dout,
  // Memory port
  output logic          mem_en,
  output logic [3:0]    mem_wen,
  output logic [2:0]    mem_strctrl,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_bad_starve_limit
    $error("shared_mem_arbiter: STARVE_LIMIT must be in 1..255");
  end

  logic       cpu_req;
  logic       ras_req;
  logic       dma_req;
  logic       sec_pending;
  logic       force_grant;
  logic       cpu_grant;
  logic       sec_grant;
  logic       ras_grant;
  logic       dma_grant;
  logic [1:0] rr_gnt;

  owner_e        owner_q;
  owner_e        owner_d;
  logic [DW-1:0] ras_data_q;
  logic [DW-1:0] dma_data_q;

  assign cpu_req     = cpu_rd | cpu_wr;
  assign ras_req     = ras_req_rd | ras_req_wr;
  assign dma_req     = dma_req_rd | dma_req_wr;
  assign sec_pending = ras_req | dma_req;

  arb_rr2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({dma_req, ras_req}),
    .advance (sec_grant),
    .gnt     (rr_gnt)
  );

`ifdef SHARED_MEM_STARVE_GUARD_EN
  localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

  logic [7:0] starve_q;
  logic [7:0] starve_d;

  // Forcing clears the counter, so the hold can never repeat next cycle.
  assign force_grant = cpu_req & sec_pending & (starve_q == StarveMax);

  always_comb begin
    starve_d = starve_q;
    if (!sec_pending || sec_grant) begin
      starve_d = 8'd0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 8'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_grant = 1'b0;
`endif

  // Nothing is granted while reset is asserted, even mid-access.
  assign cpu_grant = ~rst & cpu_req & ~force_grant;
  assign sec_grant = ~rst & sec_pending & (~cpu_req | force_grant);
  assign ras_grant = sec_grant & rr_gnt[0];
  assign dma_grant = sec_grant & rr_gnt[1];

  assign cpu_hold = ~rst & force_grant;
  assign ras_gnt  = ras_grant;
  assign dma_gnt  = dma_grant;

  // Port mux and owner of the read issued this cycle.
  always_comb begin
    mem_en      = 1'b0;
    mem_wen     = WEN_NONE;
    mem_strctrl = STORE_NONE;
    mem_addr    = '0;
    mem_din     = '0;
    owner_d     = OWN_NONE;
    if (cpu_grant) begin
      mem_en   = 1'b1;
      mem_addr = cpu_addr - BASE_OFFSET;
      mem_din  = cpu_din;
      if (cpu_wr) begin
        mem_wen     = cpu_wen;
        mem_strctrl = cpu_strctrl;
      end
      if (cpu_rd) begin
        owner_d = OWN_CPU;
      end
    end else if (ras_grant) begin
      mem_en   = 1'b1;
      mem_addr = ras_addr - BASE_OFFSET;
      mem_din  = ras_din;
      if (ras_req_wr) begin
        mem_wen     = WEN_WORD;
        mem_strctrl = STORE_WORD;
      end else begin
        owner_d = OWN_RAS;
      end
    end else if (dma_grant) begin
      mem_en   = 1'b1;
      mem_addr = dma_addr - BASE_OFFSET;
      mem_din  = dma_din;
      if (dma_req_wr) begin
        mem_wen     = WEN_WORD;
        mem_strctrl = STORE_WORD;
      end else begin
        owner_d = OWN_DMA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // A read still in flight when reset arrives is dropped silently.
  assign ras_rvalid = ~rst & (owner_q == OWN_RAS);
  assign dma_rvalid = ~rst & (owner_q == OWN_DMA);

  always_ff @(posedge clk) begin
    if (rst) begin
      ras_data_q <= '0;
      dma_data_q <= '0;
    end else begin
      if (ras_rvalid) begin
        ras_data_q <= mem_dout;
      end
      if (dma_rvalid) begin
        dma_data_q <= mem_dout;
      end
    end
  end

  assign cpu_dout = mem_dout;
  assign ras_dout = rst ? '0 : (ras_rvalid ? mem_dout : ras_data_q);
  assign dma_dout = rst ? '0 : (dma_rvalid ? mem_dout : dma_data_q);

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Self-checking bench for shared_mem_arbiter (defaults: BASE_OFFSET 0x2000,
// STARVE_LIMIT 8). Single-cycle grant/mux behaviour is table driven; read
// return, round-robin, starvation and reset are hand-written sequences.
module tb_shared_mem_arbiter;

`ifdef SHARED_MEM_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_din, cpu_dout;
  logic [3:0]  cpu_wen;
  logic [2:0]  cpu_strctrl;
  logic        cpu_hold;
  logic        ras_req_rd, ras_req_wr, ras_gnt, ras_rvalid;
  logic [31:0] ras_addr, ras_din, ras_dout;
  logic        dma_req_rd, dma_req_wr, dma_gnt, dma_rvalid;
  logic [31:0] dma_addr, dma_din, dma_dout;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [2:0]  mem_strctrl;
  logic [31:0] mem_addr, mem_din, mem_dout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shared_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_wen     (cpu_wen),
    .cpu_strctrl (cpu_strctrl),
    .cpu_dout    (cpu_dout),
    .cpu_hold    (cpu_hold),
    .ras_req_rd  (ras_req_rd),
    .ras_req_wr  (ras_req_wr),
    .ras_addr    (ras_addr),
    .ras_din     (ras_din),
    .ras_gnt     (ras_gnt),
    .ras_rvalid  (ras_rvalid),
    .ras_dout    (ras_dout),
    .dma_req_rd  (dma_req_rd),
    .dma_req_wr  (dma_req_wr),
    .dma_addr    (dma_addr),
    .dma_din     (dma_din),
    .dma_gnt     (dma_gnt),
    .dma_rvalid  (dma_rvalid),
    .dma_dout    (dma_dout),
    .mem_en      (mem_en),
    .mem_wen     (mem_wen),
    .mem_strctrl (mem_strctrl),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout)
  );

  typedef struct {
    string       name;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_din;
    logic [3:0]  cpu_wen;
    logic [2:0]  cpu_strctrl;
    logic        ras_rd, ras_wr;
    logic [31:0] ras_addr, ras_din;
    logic        dma_rd, dma_wr;
    logic [31:0] dma_addr, dma_din;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wen;
    logic [2:0]  exp_strc;
    logic [31:0] exp_din;
    logic        exp_ras_gnt, exp_dma_gnt, exp_hold;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = '0;
    cpu_wen = '0; cpu_strctrl = '0;
    ras_req_rd = 1'b0; ras_req_wr = 1'b0; ras_addr = '0; ras_din = '0;
    dma_req_rd = 1'b0; dma_req_wr = 1'b0; dma_addr = '0; dma_din = '0;
  endtask

  // Returns 1 time unit after a posedge with reset released.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    mem_dout = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    cpu_rd = v.cpu_rd; cpu_wr = v.cpu_wr; cpu_addr = v.cpu_addr; cpu_din = v.cpu_din;
    cpu_wen = v.cpu_wen; cpu_strctrl = v.cpu_strctrl;
    ras_req_rd = v.ras_rd; ras_req_wr = v.ras_wr; ras_addr = v.ras_addr; ras_din = v.ras_din;
    dma_req_rd = v.dma_rd; dma_req_wr = v.dma_wr; dma_addr = v.dma_addr; dma_din = v.dma_din;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        exp_b;
    logic [31:0] ras_last;
    logic [31:0] dma_last;

    // name, cpu rd/wr/addr/din/wen/strc, ras rd/wr/addr/din, dma rd/wr/addr/din,
    // exp en/addr/wen/strc/din/ras_gnt/dma_gnt/hold
    vecs[0] = '{"cpu_rd", 1'b1, 1'b0, 32'h2010, 32'h0, 4'h0, 3'b000,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b1, 32'h10, 4'h0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"cpu_wr", 1'b0, 1'b1, 32'h2024, 32'h1122_3344, 4'h3, 3'b010,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b1, 32'h24, 4'h3, 3'b010, 32'h1122_3344, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"ras_wr", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000,
                1'b0, 1'b1, 32'h2040, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b1, 32'h40, 4'hF, 3'b100, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"dma_rd_wrap", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0,
                1'b1, 32'hFFFF_E000, 4'h0, 3'b000, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{"ras_dma_tie", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000,
                1'b1, 1'b0, 32'h2100, 32'h0, 1'b1, 1'b0, 32'h2200, 32'h0,
                1'b1, 32'h100, 4'h0, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{"all_three", 1'b1, 1'b0, 32'h2008, 32'h0, 4'h0, 3'b000,
                1'b0, 1'b1, 32'h2040, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h2080, 32'h0,
                1'b1, 32'h8, 4'h0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"dma_wr", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h2FFC, 32'h1234_5678,
                1'b1, 32'hFFC, 4'hF, 3'b100, 32'h1234_5678, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{"idle", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b0, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0};

    // Reset state.
    rst = 1'b1;
    idle_inputs();
    mem_dout = 32'h0;
    @(negedge clk);
    chk("reset_mem_en", {31'b0, mem_en}, 32'h0);
    chk("reset_cpu_hold", {31'b0, cpu_hold}, 32'h0);
    chk("reset_ras_rvalid", {31'b0, ras_rvalid}, 32'h0);
    chk("reset_dma_dout", dma_dout, 32'h0);

    // Table: each vector from a fresh reset, checked in the same cycle.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      apply_vec(vecs[i]);
      @(negedge clk);
      chk({vecs[i].name, "_mem_en"}, {31'b0, mem_en}, {31'b0, vecs[i].exp_en});
      chk({vecs[i].name, "_mem_addr"}, mem_addr, vecs[i].exp_addr);
      chk({vecs[i].name, "_mem_wen"}, {28'b0, mem_wen}, {28'b0, vecs[i].exp_wen});
      chk({vecs[i].name, "_mem_strctrl"}, {29'b0, mem_strctrl}, {29'b0, vecs[i].exp_strc});
      chk({vecs[i].name, "_mem_din"}, mem_din, vecs[i].exp_din);
      chk({vecs[i].name, "_ras_gnt"}, {31'b0, ras_gnt}, {31'b0, vecs[i].exp_ras_gnt});
      chk({vecs[i].name, "_dma_gnt"}, {31'b0, dma_gnt}, {31'b0, vecs[i].exp_dma_gnt});
      chk({vecs[i].name, "_cpu_hold"}, {31'b0, cpu_hold}, {31'b0, vecs[i].exp_hold});
    end

    // CPU read: data returns next cycle on cpu_dout only.
    do_reset();
    cpu_rd = 1'b1; cpu_addr = 32'h2010;
    @(negedge clk);
    chk("cpurd_addr", mem_addr, 32'h10);
    next_cycle();
    cpu_rd = 1'b0; mem_dout = 32'h1357_9BDF;
    @(negedge clk);
    chk("cpurd_dout", cpu_dout, 32'h1357_9BDF);
    chk("cpurd_ras_rvalid", {31'b0, ras_rvalid}, 32'h0);
    chk("cpurd_dma_rvalid", {31'b0, dma_rvalid}, 32'h0);

    // RAS write + DMA read together, CPU idle.
    do_reset();
    ras_req_wr = 1'b1; ras_addr = 32'h2040; ras_din = 32'hDEAD_BEEF;
    dma_req_rd = 1'b1; dma_addr = 32'h2080;
    @(negedge clk);
    chk("rd_c0_ras_gnt", {31'b0, ras_gnt}, 32'h1);
    chk("rd_c0_dma_gnt", {31'b0, dma_gnt}, 32'h0);
    chk("rd_c0_wen", {28'b0, mem_wen}, 32'hF);
    chk("rd_c0_strctrl", {29'b0, mem_strctrl}, 32'h4);
    next_cycle();
    ras_req_wr = 1'b0;
    @(negedge clk);
    chk("rd_c1_dma_gnt", {31'b0, dma_gnt}, 32'h1);
    chk("rd_c1_addr", mem_addr, 32'h80);
    chk("rd_c1_ras_rvalid", {31'b0, ras_rvalid}, 32'h0);
    next_cycle();
    dma_req_rd = 1'b0; mem_dout = 32'hCAFE_0001;
    @(negedge clk);
    chk("rd_c2_dma_rvalid", {31'b0, dma_rvalid}, 32'h1);
    chk("rd_c2_dma_dout", dma_dout, 32'hCAFE_0001);
    next_cycle();
    mem_dout = 32'h0000_0055;
    @(negedge clk);
    chk("rd_c3_dma_rvalid", {31'b0, dma_rvalid}, 32'h0);
    chk("rd_c3_dma_dout_held", dma_dout, 32'hCAFE_0001);

    // Starvation: CPU reads continuously, RAS reads 0x2300.
    do_reset();
    cpu_rd = 1'b1; cpu_addr = 32'h2000;
    ras_addr = 32'h2300;
    for (int c = 0; c < 12; c++) begin
      ras_req_rd = Guard ? (c <= 8) : 1'b1;
      @(negedge clk);
      exp_b = Guard && (c == 8);
      chk($sformatf("starve_c%0d_ras_gnt", c), {31'b0, ras_gnt}, {31'b0, exp_b});
      chk($sformatf("starve_c%0d_cpu_hold", c), {31'b0, cpu_hold}, {31'b0, exp_b});
      chk($sformatf("starve_c%0d_addr", c), mem_addr, exp_b ? 32'h300 : 32'h0);
      exp_b = Guard && (c == 9);
      chk($sformatf("starve_c%0d_ras_rvalid", c), {31'b0, ras_rvalid}, {31'b0, exp_b});
      next_cycle();
    end
    cpu_rd = 1'b0;
    ras_req_rd = !Guard;
    @(negedge clk);
    chk("starve_idle_ras_gnt", {31'b0, ras_gnt}, {31'b0, !Guard});

    // Round robin: RAS and DMA reads held for 6 CPU-idle cycles.
    do_reset();
    ras_addr = 32'h2400; dma_addr = 32'h2500;
    ras_last = 32'h0; dma_last = 32'h0;
    for (int c = 0; c < 7; c++) begin
      ras_req_rd = (c < 6);
      dma_req_rd = (c < 6);
      mem_dout = 32'hA000_0000 + 32'(c);
      @(negedge clk);
      exp_b = (c < 6) && (c % 2 == 0);
      chk($sformatf("rr_c%0d_ras_gnt", c), {31'b0, ras_gnt}, {31'b0, exp_b});
      exp_b = (c < 6) && (c % 2 == 1);
      chk($sformatf("rr_c%0d_dma_gnt", c), {31'b0, dma_gnt}, {31'b0, exp_b});
      exp_b = (c >= 1) && ((c - 1) % 2 == 0);
      if (exp_b) ras_last = mem_dout;
      chk($sformatf("rr_c%0d_ras_rvalid", c), {31'b0, ras_rvalid}, {31'b0, exp_b});
      exp_b = (c >= 1) && ((c - 1) % 2 == 1);
      if (exp_b) dma_last = mem_dout;
      chk($sformatf("rr_c%0d_dma_rvalid", c), {31'b0, dma_rvalid}, {31'b0, exp_b});
      chk($sformatf("rr_c%0d_ras_dout", c), ras_dout, ras_last);
      chk($sformatf("rr_c%0d_dma_dout", c), dma_dout, dma_last);
      next_cycle();
    end

    // Reset the cycle after a RAS read grant.
    do_reset();
    ras_req_rd = 1'b1; ras_addr = 32'h2600;
    dma_req_rd = 1'b1; dma_addr = 32'h2700;
    @(negedge clk);
    chk("rstmid_c0_ras_gnt", {31'b0, ras_gnt}, 32'h1);
    next_cycle();
    rst = 1'b1;
    mem_dout = 32'h7777_7777;
    @(negedge clk);
    chk("rstmid_ras_rvalid", {31'b0, ras_rvalid}, 32'h0);
    chk("rstmid_ras_gnt", {31'b0, ras_gnt}, 32'h0);
    chk("rstmid_dma_gnt", {31'b0, dma_gnt}, 32'h0);
    chk("rstmid_mem_en", {31'b0, mem_en}, 32'h0);
    chk("rstmid_mem_addr", mem_addr, 32'h0);
    chk("rstmid_mem_din", mem_din, 32'h0);
    chk("rstmid_ras_dout", ras_dout, 32'h0);
    chk("rstmid_cpu_hold", {31'b0, cpu_hold}, 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_after_ras_gnt", {31'b0, ras_gnt}, 32'h1);
    chk("rstmid_after_dma_gnt", {31'b0, dma_gnt}, 32'h0);
    chk("rstmid_after_ras_rvalid", {31'b0, ras_rvalid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
